// File: rtl/mesi_pkg.sv
// Shared MESI encodings: line states, processor actions, bus and memory messages.
package mesi_pkg;

  // Line states
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  // Processor actions (requester mode)
  localparam logic [1:0] ACT_RD_MISS = 2'b00;
  localparam logic [1:0] ACT_RD_HIT  = 2'b01;
  localparam logic [1:0] ACT_WR_MISS = 2'b10;
  localparam logic [1:0] ACT_WR_HIT  = 2'b11;

  // Bus messages (snooped and broadcast)
  localparam logic [1:0] BUS_NONE    = 2'b00;
  localparam logic [1:0] BUS_RD_MISS = 2'b01;
  localparam logic [1:0] BUS_WR_MISS = 2'b10;
  localparam logic [1:0] BUS_INV     = 2'b11;

  // Memory / data-transfer messages
  localparam logic [1:0] MEM_NONE   = 2'b00;
  localparam logic [1:0] MEM_SUPPLY = 2'b01;
  localparam logic [1:0] MEM_FETCH  = 2'b10;
  localparam logic [1:0] MEM_WB     = 2'b11;

  // Field layout of the ctrl input
  typedef struct packed {
    logic       mode;    // 1 = requester, 0 = snooper
    logic [1:0] action;
    logic       shared;
  } ctrl_t;

  // Everything the controller registers in one bundle
  typedef struct packed {
    logic [1:0] bus_msg;
    logic [1:0] mem_msg;
    logic [1:0] state;
  } ctl_out_t;

endpackage

// File: rtl/mesi_controller.sv
// Per-line MESI coherence controller: combinational transition function
// followed by a single registered output stage (one-cycle latency).
module mesi_controller
  import mesi_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] ctrl,
  input  logic [1:0] bus_msg_in,
  input  logic [1:0] cur_state,
  output logic [1:0] bus_msg_out,
  output logic [1:0] mem_msg_out,
  output logic [1:0] next_state
);

  ctrl_t      ctrl_s;
  logic [1:0] eff_action;
  ctl_out_t   out_d;
  ctl_out_t   out_q;

  assign ctrl_s = ctrl_t'(ctrl);

  // A hit on an invalid line is really a miss; fold that in before decoding.
  assign eff_action = (cur_state == ST_I) ? {ctrl_s.action[1], 1'b0} : ctrl_s.action;

  // Transition function: next state plus the messages to broadcast.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statements can leave it unassigned (latch).
    out_d.bus_msg = BUS_NONE;
    out_d.mem_msg = MEM_NONE;
    out_d.state   = cur_state;

    if (ctrl_s.mode) begin
      unique case (eff_action)
        ACT_RD_MISS: begin
          out_d.bus_msg = BUS_RD_MISS;
          out_d.mem_msg = (cur_state == ST_M) ? MEM_WB : MEM_FETCH;
          out_d.state   = ctrl_s.shared ? ST_S : ST_E;
        end
        ACT_RD_HIT: begin
          out_d.state = cur_state;
        end
        ACT_WR_MISS: begin
          out_d.bus_msg = BUS_WR_MISS;
          out_d.mem_msg = (cur_state == ST_M) ? MEM_WB : MEM_FETCH;
          out_d.state   = ST_M;
        end
        ACT_WR_HIT: begin
          // Only a shared copy needs to invalidate the others.
          out_d.bus_msg = (cur_state == ST_S) ? BUS_INV : BUS_NONE;
          out_d.state   = ST_M;
        end
        default: ;
      endcase
    end else begin
      unique case (bus_msg_in)
        BUS_RD_MISS: begin
          // An exclusive owner supplies the block and drops to shared.
          if (cur_state == ST_M || cur_state == ST_E) begin
            out_d.mem_msg = MEM_SUPPLY;
            out_d.state   = ST_S;
          end
        end
        BUS_WR_MISS: begin
          // Only a dirty copy has data worth supplying.
          out_d.mem_msg = (cur_state == ST_M) ? MEM_SUPPLY : MEM_NONE;
          out_d.state   = ST_I;
        end
        BUS_INV: begin
          out_d.state = ST_I;
        end
        default: ;
      endcase
    end
  end

  // Output register with synchronous clear taking priority.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its pre-edge value regardless of statement order.
    if (clear) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus_msg_out = out_q.bus_msg;
  assign mem_msg_out = out_q.mem_msg;
  assign next_state  = out_q.state;

endmodule

// File: tb/tb_mesi_controller.sv
// Self-checking bench for mesi_controller: directed literal cases, reset
// checks, then randomized traffic compared against a behavioural model.
module tb_mesi_controller;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] ctrl;
  logic [1:0] bus_msg_in;
  logic [1:0] cur_state;
  logic [1:0] bus_msg_out;
  logic [1:0] mem_msg_out;
  logic [1:0] next_state;

  int n_checks = 0;
  int n_errors = 0;

  mesi_controller dut (
    .clock      (clock),
    .clear      (clear),
    .ctrl       (ctrl),
    .bus_msg_in (bus_msg_in),
    .cur_state  (cur_state),
    .bus_msg_out(bus_msg_out),
    .mem_msg_out(mem_msg_out),
    .next_state (next_state)
  );

  always #5 clock = ~clock;

  // Values packed as {bus_msg_out, mem_msg_out, next_state}.
  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got bus=%b mem=%b ns=%b, want bus=%b mem=%b ns=%b",
               name, act[5:4], act[3:2], act[1:0], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  // Behavioural model written from the protocol rules.
  function automatic logic [5:0] model(input logic clr, input logic [3:0] c,
                                       input logic [1:0] bm, input logic [1:0] cs);
    logic       is_write, is_hit, dirty, owner;
    logic [1:0] bus, mem, ns;
    is_write = c[2];
    is_hit   = c[1] && (cs != 2'd0);
    dirty    = (cs == 2'd3);
    owner    = (cs >= 2'd2);
    bus = 2'd0; mem = 2'd0; ns = cs;
    if (clr) return 6'd0;
    if (c[3]) begin
      if (!is_hit) begin
        bus = is_write ? 2'd2 : 2'd1;
        mem = dirty ? 2'd3 : 2'd2;
        ns  = is_write ? 2'd3 : (c[0] ? 2'd1 : 2'd2);
      end else if (is_write) begin
        bus = (cs == 2'd1) ? 2'd3 : 2'd0;
        ns  = 2'd3;
      end
    end else begin
      if (bm == 2'd1) begin
        mem = owner ? 2'd1 : 2'd0;
        ns  = (cs == 2'd0) ? 2'd0 : 2'd1;
      end else if (bm == 2'd2) begin
        mem = dirty ? 2'd1 : 2'd0;
        ns  = 2'd0;
      end else if (bm == 2'd3) begin
        ns  = 2'd0;
      end
    end
    return {bus, mem, ns};
  endfunction

  // Apply one input vector across an edge and compare DUT against model
  // (and, when given, against a hand-computed literal).
  task automatic step(input string name, input logic clr, input logic [3:0] c,
                      input logic [1:0] bm, input logic [1:0] cs,
                      input bit has_lit, input logic [5:0] lit);
    logic [5:0] exp;
    clear = clr; ctrl = c; bus_msg_in = bm; cur_state = cs;
    exp = model(clr, c, bm, cs);
    @(posedge clock);
    #1;
    if (has_lit) begin
      check({name, "_model"}, exp, lit);
      check(name, {bus_msg_out, mem_msg_out, next_state}, lit);
    end else begin
      check(name, {bus_msg_out, mem_msg_out, next_state}, exp);
    end
  endtask

  initial begin
    clear = 1'b1; ctrl = 4'b1111; bus_msg_in = 2'b11; cur_state = 2'b11;
    #2;

    // Reset with arbitrary inputs, held for several cycles.
    for (int i = 0; i < 4; i++)
      step("reset_hold", 1'b1, 4'($urandom), 2'($urandom), 2'($urandom), 1'b1, 6'b00_00_00);

    // Requester directed cases.
    step("rq_rdmiss_I_unshared", 1'b0, 4'b1000, 2'b00, 2'b00, 1'b1, 6'b01_10_10);
    step("rq_rdmiss_I_shared",   1'b0, 4'b1001, 2'b00, 2'b00, 1'b1, 6'b01_10_01);
    step("rq_wrhit_S",           1'b0, 4'b1110, 2'b00, 2'b01, 1'b1, 6'b11_00_11);
    step("rq_wrhit_E",           1'b0, 4'b1110, 2'b00, 2'b10, 1'b1, 6'b00_00_11);
    step("rq_wrmiss_M",          1'b0, 4'b1100, 2'b00, 2'b11, 1'b1, 6'b10_11_11);
    step("rq_rdhit_I_as_miss",   1'b0, 4'b1010, 2'b00, 2'b00, 1'b1, 6'b01_10_10);
    step("rq_rdhit_E",           1'b0, 4'b1011, 2'b11, 2'b10, 1'b1, 6'b00_00_10);
    step("rq_wrhit_I_as_miss",   1'b0, 4'b1110, 2'b00, 2'b00, 1'b1, 6'b10_10_11);

    // Snooper directed cases.
    step("sn_rdmiss_M",          1'b0, 4'b0000, 2'b01, 2'b11, 1'b1, 6'b00_01_01);
    step("sn_wrmiss_M",          1'b0, 4'b0000, 2'b10, 2'b11, 1'b1, 6'b00_01_00);
    step("sn_wrmiss_E",          1'b0, 4'b0000, 2'b10, 2'b10, 1'b1, 6'b00_00_00);
    step("sn_inv_S",             1'b0, 4'b0000, 2'b11, 2'b01, 1'b1, 6'b00_00_00);
    step("sn_none_S",            1'b0, 4'b0000, 2'b00, 2'b01, 1'b1, 6'b00_00_01);
    step("sn_none_S_actbits",    1'b0, 4'b0111, 2'b00, 2'b01, 1'b1, 6'b00_00_01);
    step("sn_rdmiss_E_actbits",  1'b0, 4'b0101, 2'b01, 2'b10, 1'b1, 6'b00_01_01);

    // Reset overrides a live operation.
    step("reset_priority",       1'b1, 4'b1100, 2'b00, 2'b11, 1'b1, 6'b00_00_00);

    // Randomized traffic, occasional clear, occasional repeated vectors.
    for (int i = 0; i < 3000; i++) begin
      logic       clr;
      logic [3:0] c;
      logic [1:0] bm, cs;
      int         reps;
      clr  = ($urandom_range(0, 15) == 0);
      c    = 4'($urandom);
      bm   = 2'($urandom);
      cs   = 2'($urandom);
      reps = ($urandom_range(0, 7) == 0) ? 2 : 1;
      for (int r = 0; r < reps; r++)
        step("random", clr, c, bm, cs, 1'b0, 6'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
